// File: rtl/sonic_pcs_pkg.sv
// Shared 10GBASE-R PCS constants, block type and the payload scrambler helper
// used by the TX channel back end.
package sonic_pcs_pkg;

  typedef logic [65:0] block66_t;

  localparam logic [1:0]  SYNC_DATA  = 2'b10;
  localparam logic [1:0]  SYNC_CTRL  = 2'b01;
  localparam logic [7:0]  BT_IDLE    = 8'h1E;
  localparam block66_t    IDLE_BLOCK = {56'h0, BT_IDLE, SYNC_CTRL};
  localparam logic [57:0] SCRAM_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [57:0] state;
    logic [63:0] data;
  } scram_res_t;

  // Self-synchronous 1 + x^39 + x^58; state[0] holds the most recent output bit.
  function automatic scram_res_t scramble64(input logic [63:0] payload,
                                            input logic [57:0] state);
    scram_res_t  res;
    logic [57:0] s;
    logic        b;
    res = '0;
    s   = state;
    for (int i = 0; i < 64; i++) begin
      b           = payload[i] ^ s[38] ^ s[57];
      res.data[i] = b;
      s           = {s[56:0], b};
    end
    res.state = s;
    return res;
  endfunction

endpackage

// File: rtl/sonic_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; the head is only visible
// once the entry has been written, so there is no empty-FIFO bypass.
module sonic_sync_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  // Qualify requests so the storage can never over- or under-run.
  always_comb begin
    push_s = push && (count_r != (AW+1)'(DEPTH));
    pop_s  = pop && (count_r != '0);
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) wptr_r <= wptr_r + AW'(1);
      if (pop_s)  rptr_r <= rptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rptr_r];
  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/sonic_tx_gearbox_66_w.sv
// TX back end: 66-bit block FIFO, payload scrambler, 66->DOUT_W gearbox, idle fill.
// Optional SONIC_TX_GEARBOX_STATS_EN adds pop/idle counters with stat_clr.
module sonic_tx_gearbox_66_w
  import sonic_pcs_pkg::*;
#(
  parameter int DOUT_W       = 40,
  parameter int FIFO_DEPTH   = 8,
  parameter int SCRAM_BYPASS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xcvr_tx_ready,
  input  logic [65:0]       din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DOUT_W-1:0] dout,
  output logic              underflow
`ifdef SONIC_TX_GEARBOX_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [31:0]       stat_blocks,
  output logic [31:0]       stat_idles
`endif
);

  localparam int BUF_W = 66 + DOUT_W;
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  block66_t          fifo_head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [FCW-1:0]    fifo_count_s;
  logic [BUF_W-1:0]  buf_r;
  logic [BUF_W-1:0]  merged_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [57:0]       scr_r;
  logic [57:0]       scr_next_s;
  scram_res_t        scr_res_s;
  block66_t          blk_raw_s;
  block66_t          blk_tx_s;
  logic              load_s;
  logic              pop_s;
  logic              idle_s;
  logic [DOUT_W-1:0] dout_r;
  logic              underflow_r;

  sonic_sync_fifo #(
    .WIDTH (66),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (din_valid && !fifo_full_s),
    .wdata (din),
    .pop   (pop_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign din_ready = (fifo_count_s < FCW'(FIFO_DEPTH));

  // Block selection, scrambling and bit-buffer merge for this cycle.
  always_comb begin
    load_s    = (cnt_r < CNT_W'(DOUT_W));
    pop_s     = xcvr_tx_ready && load_s && !fifo_empty_s;
    idle_s    = xcvr_tx_ready && load_s && fifo_empty_s;
    blk_raw_s = fifo_empty_s ? IDLE_BLOCK : fifo_head_s;
    scr_res_s = scramble64(blk_raw_s[65:2], scr_r);
    if (SCRAM_BYPASS != 0) begin
      blk_tx_s   = blk_raw_s;
      scr_next_s = scr_r;
    end else begin
      blk_tx_s   = {scr_res_s.data, blk_raw_s[1:0]};
      scr_next_s = scr_res_s.state;
    end
    if (load_s) begin
      merged_s   = buf_r | (BUF_W'(blk_tx_s) << cnt_r);
      cnt_next_s = cnt_r + CNT_W'(66 - DOUT_W);
    end else begin
      merged_s   = buf_r;
      cnt_next_s = cnt_r - CNT_W'(DOUT_W);
    end
  end

  // Gearbox state; underflow is registered so it lines up with the first
  // dout word carrying the inserted idle block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r       <= '0;
      buf_r       <= '0;
      dout_r      <= '0;
      underflow_r <= 1'b0;
      scr_r       <= SCRAM_SEED;
    end else if (!xcvr_tx_ready) begin
      cnt_r       <= '0;
      buf_r       <= '0;
      dout_r      <= '0;
      underflow_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_next_s;
      buf_r       <= merged_s >> DOUT_W;
      dout_r      <= merged_s[DOUT_W-1:0];
      underflow_r <= idle_s;
      if (load_s) begin
        scr_r <= scr_next_s;
      end
    end
  end

  assign dout      = dout_r;
  assign underflow = underflow_r;

`ifdef SONIC_TX_GEARBOX_STATS_EN
  logic [31:0] stat_blocks_r;
  logic [31:0] stat_idles_r;

  // Saturating pop / idle counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_blocks_r <= 32'h0;
      stat_idles_r  <= 32'h0;
    end else if (stat_clr) begin
      stat_blocks_r <= 32'h0;
      stat_idles_r  <= 32'h0;
    end else begin
      if (pop_s && (stat_blocks_r != 32'hFFFF_FFFF)) stat_blocks_r <= stat_blocks_r + 32'h1;
      if (idle_s && (stat_idles_r != 32'hFFFF_FFFF)) stat_idles_r <= stat_idles_r + 32'h1;
    end
  end

  assign stat_blocks = stat_blocks_r;
  assign stat_idles  = stat_idles_r;
`endif

endmodule

// File: tb/tb_sonic_tx_gearbox_66_w.sv
// Self-checking bench: four DUT variants (W40, W32, W64 scrambled; W40 bypass)
// checked against a bit-queue reference model plus directed tables/sequences.
`timescale 1ns/1ps
module tb_sonic_tx_gearbox_66_w;
  import sonic_pcs_pkg::*;

  localparam int NI    = 4;
  localparam int DEPTH = 8;
  localparam int WID [NI] = '{40, 32, 64, 40};
  localparam bit BYP [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rdy = 1'b0;
  logic [65:0] din = '0;
  logic        vld  [NI];
  logic        drdy [NI];
  logic        uf   [NI];
  logic [39:0] dout0;
  logic [31:0] dout1;
  logic [63:0] dout2;
  logic [39:0] dout3;

  always #5 clk = ~clk;

`ifdef SONIC_TX_GEARBOX_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] sb [NI];
  logic [31:0] si [NI];
`define STATS_PORTS(n) , .stat_clr(stat_clr), .stat_blocks(sb[n]), .stat_idles(si[n])
`else
`define STATS_PORTS(n)
`endif

  sonic_tx_gearbox_66_w #(.DOUT_W(40), .FIFO_DEPTH(DEPTH), .SCRAM_BYPASS(0)) u_w40 (
    .clk(clk), .reset(reset), .xcvr_tx_ready(rdy), .din(din), .din_valid(vld[0]),
    .din_ready(drdy[0]), .dout(dout0), .underflow(uf[0]) `STATS_PORTS(0));
  sonic_tx_gearbox_66_w #(.DOUT_W(32), .FIFO_DEPTH(DEPTH), .SCRAM_BYPASS(0)) u_w32 (
    .clk(clk), .reset(reset), .xcvr_tx_ready(rdy), .din(din), .din_valid(vld[1]),
    .din_ready(drdy[1]), .dout(dout1), .underflow(uf[1]) `STATS_PORTS(1));
  sonic_tx_gearbox_66_w #(.DOUT_W(64), .FIFO_DEPTH(DEPTH), .SCRAM_BYPASS(0)) u_w64 (
    .clk(clk), .reset(reset), .xcvr_tx_ready(rdy), .din(din), .din_valid(vld[2]),
    .din_ready(drdy[2]), .dout(dout2), .underflow(uf[2]) `STATS_PORTS(2));
  sonic_tx_gearbox_66_w #(.DOUT_W(40), .FIFO_DEPTH(DEPTH), .SCRAM_BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .xcvr_tx_ready(rdy), .din(din), .din_valid(vld[3]),
    .din_ready(drdy[3]), .dout(dout3), .underflow(uf[3]) `STATS_PORTS(3));

  // Reference model: pending blocks, serial bit stream, scrambler output history.
  logic [65:0] fq   [NI][$];
  bit          bq   [NI][$];
  bit          hist [NI][$];
  logic [63:0] exp_dout [NI];
  logic        exp_uf   [NI];
  logic [65:0] sent2 [$];
  bit          rxq   [$];
  bit          dhist [$];
  bit          desc_en = 1'b0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    logic        r;
    logic        v;
    logic [65:0] d;
    logic        exp_rdy;
    logic [65:0] exp_db;
    logic        exp_uf;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_dout(input int i);
    case (i)
      0:       return 64'(dout0);
      1:       return 64'(dout1);
      2:       return dout2;
      default: return 64'(dout3);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      fq[i].delete();
      bq[i].delete();
      hist[i].delete();
      for (int k = 0; k < 58; k++) hist[i].push_back(1'b1);
      exp_dout[i] = '0;
      exp_uf[i]   = 1'b0;
    end
    sent2.delete();
    rxq.delete();
    dhist.delete();
    for (int k = 0; k < 58; k++) dhist.push_back(1'b1);
  endtask

  // out[n] = in[n] ^ out[n-39] ^ out[n-58]; hist[0] is 58 bits ago.
  task automatic model_load(input int i, input logic [65:0] blk);
    logic [65:0] tx;
    bit          o;
    tx = blk;
    if (!BYP[i]) begin
      for (int k = 2; k < 66; k++) begin
        o     = blk[k] ^ hist[i][19] ^ hist[i][0];
        tx[k] = o;
        hist[i].push_back(o);
        void'(hist[i].pop_front());
      end
    end
    for (int k = 0; k < 66; k++) bq[i].push_back(tx[k]);
  endtask

  task automatic model_step(input int i, input bit push);
    logic [65:0] blk;
    logic [63:0] w;
    if (rdy) begin
      exp_uf[i] = 1'b0;
      if (bq[i].size() < WID[i]) begin
        if (fq[i].size() > 0) blk = fq[i].pop_front();
        else begin
          blk       = IDLE_BLOCK;
          exp_uf[i] = 1'b1;
        end
        if (i == 2 && desc_en) sent2.push_back(blk);
        model_load(i, blk);
      end
      w = '0;
      for (int k = 0; k < WID[i]; k++) w[k] = bq[i].pop_front();
      exp_dout[i] = w;
    end else begin
      bq[i].delete();
      exp_dout[i] = '0;
      exp_uf[i]   = 1'b0;
    end
    if (push) fq[i].push_back(din);
  endtask

  // Receiver side for the W64 variant: regroup 66-bit blocks and descramble.
  task automatic descramble_w64();
    logic [65:0] r;
    logic [65:0] d;
    logic [65:0] e;
    for (int k = 0; k < 64; k++) rxq.push_back(dout2[k]);
    while (rxq.size() >= 66) begin
      for (int k = 0; k < 66; k++) r[k] = rxq.pop_front();
      d = r;
      for (int k = 2; k < 66; k++) begin
        d[k] = r[k] ^ dhist[19] ^ dhist[0];
        dhist.push_back(r[k]);
        void'(dhist.pop_front());
      end
      e = (sent2.size() > 0) ? sent2.pop_front() : ~d;
      check("descrambled_w64", d, e);
    end
  endtask

  // One clock: inputs already driven; check din_ready, step model, check outputs.
  task automatic cycle();
    bit push [NI];
    bit er;
    for (int i = 0; i < NI; i++) begin
      er = (fq[i].size() < DEPTH);
      check($sformatf("din_ready_%0d", i), 66'(drdy[i]), 66'(er));
      push[i] = vld[i] && er;
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i, push[i]);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("dout_%0d", i), 66'(dut_dout(i)), 66'(exp_dout[i]));
      check($sformatf("underflow_%0d", i), 66'(uf[i]), 66'(exp_uf[i]));
    end
    if (desc_en) descramble_w64();
  endtask

  // Asynchronous reset mid-cycle: outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rst_dout_%0d", i), 66'(dut_dout(i)), 66'h0);
      check($sformatf("rst_din_ready_%0d", i), 66'(drdy[i]), 66'h1);
      check($sformatf("rst_underflow_%0d", i), 66'(uf[i]), 66'h0);
    end
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic set_vld(input logic v);
    for (int i = 0; i < NI; i++) vld[i] = v;
  endtask

  initial begin
    logic [131:0] cat;
    int           nrdy;
    int           nuf;

    for (int i = 0; i < NI; i++) vld[i] = 1'b0;

    // Directed table: idle fill after reset, then fill FIFO with ready low.
    for (int r = 0; r < 13; r++) begin
      tbl[r].d = {64'h0123_4567_89AB_CDEF + 64'(r), SYNC_DATA};
      tbl[r].r = 1'b0; tbl[r].v = 1'b1; tbl[r].exp_rdy = 1'b1;
      tbl[r].exp_db = '0; tbl[r].exp_uf = 1'b0;
    end
    tbl[0].r = 1'b1; tbl[0].v = 1'b0; tbl[0].exp_db = 66'h79;         tbl[0].exp_uf = 1'b1;
    tbl[1].r = 1'b1; tbl[1].v = 1'b0; tbl[1].exp_db = 66'h1_E400_0000; tbl[1].exp_uf = 1'b1;
    tbl[10].exp_rdy = 1'b0;
    tbl[11].r = 1'b1; tbl[11].v = 1'b0; tbl[11].exp_rdy = 1'b0;
    tbl[11].exp_db = 66'(tbl[2].d[39:0]);
    cat = {tbl[3].d, tbl[2].d};
    tbl[12].r = 1'b1; tbl[12].v = 1'b0; tbl[12].exp_rdy = 1'b1;
    tbl[12].exp_db = 66'(cat[79:40]);

    do_reset();
    for (int r = 0; r < 13; r++) begin
      rdy = tbl[r].r;
      set_vld(tbl[r].v);
      din = tbl[r].d;
      check($sformatf("tbl_din_ready_%0d", r), 66'(drdy[3]), 66'(tbl[r].exp_rdy));
      cycle();
      check($sformatf("tbl_dout_byp_%0d", r), 66'(dout3), tbl[r].exp_db);
      check($sformatf("tbl_underflow_%0d", r), 66'(uf[3]), 66'(tbl[r].exp_uf));
    end
    // Remaining six buffered blocks drain with no idle in between.
    for (int c = 0; c < 10; c++) begin
      cycle();
      check("drain_no_idle_w40", 66'(uf[0]), 66'h0);
      check("drain_no_idle_byp", 66'(uf[3]), 66'h0);
    end

    // Steady state W40 with a full FIFO: 20 pops per 33 cycles, no underflow.
    do_reset();
    rdy = 1'b1;
    set_vld(1'b1);
    for (int c = 0; c < 40; c++) begin
      din = {$urandom, $urandom, SYNC_DATA};
      cycle();
    end
    nrdy = 0;
    nuf  = 0;
    for (int c = 0; c < 33; c++) begin
      din = {$urandom, $urandom, SYNC_DATA};
      if (drdy[0]) nrdy++;
      cycle();
      if (uf[0]) nuf++;
    end
    check("steady_pops_per_33", 66'(nrdy), 66'd20);
    check("steady_underflows", 66'(nuf), 66'd0);

    // Random traffic, ready held high; W64 stream is descrambled and compared.
    do_reset();
    desc_en = 1'b1;
    rdy     = 1'b1;
    for (int c = 0; c < 2200; c++) begin
      din = {$urandom, $urandom, ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL};
      for (int i = 0; i < NI; i++) vld[i] = ($urandom_range(0, 99) < 60);
      cycle();
    end
    desc_en = 1'b0;

    // Ready dropped mid-block: dout held at zero, restart at bit 0, no block lost.
    rdy = 1'b0;
    set_vld(1'b0);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("ready_low_dout_w40", 66'(dout0), 66'h0);
    end
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      din = {$urandom, $urandom, ($urandom_range(0, 1) != 0) ? SYNC_DATA : SYNC_CTRL};
      for (int i = 0; i < NI; i++) vld[i] = ($urandom_range(0, 99) < 60);
      cycle();
    end

    // Asynchronous reset in the middle of an active stream.
    rdy = 1'b1;
    set_vld(1'b1);
    for (int c = 0; c < 5; c++) begin
      din = {$urandom, $urandom, SYNC_DATA};
      cycle();
    end
    do_reset();
    set_vld(1'b0);
    for (int c = 0; c < 4; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sonic_tx_gearbox_66_w.md
Name: sonic_tx_gearbox_66_w

Overview:
- Single-clock 10GBASE-R style TX channel back end: buffers 66-bit blocks, scrambles the 64-bit payload and gearboxes the stream to a parametrised output width.
- Inserts scrambled idle blocks on underflow, so the serial stream never stalls.
- Sits between the PCS encoder and the transceiver parallel TX interface, in the same clock domain as the transceiver.
- Successor to the fixed 66->40 channel: runtime-independent width, configurable depth, handshake input, idle fill.

Parameters:
- DOUT_W, 40, output word width; legal 16..66.
- FIFO_DEPTH, 8, input FIFO entries; power of 2, >=2.
- SCRAM_BYPASS, 0, 1 = payload passes unscrambled (lab/debug).

Ports:
- clk  in  1  TX parallel clock.
- reset  in  1  asynchronous, active-high.
- xcvr_tx_ready  in  1  transceiver ready; low holds the gearbox idle.
- din  in  66  block; [1:0] sync header, [65:2] payload.
- din_valid  in  1  din present.
- din_ready  out  1  FIFO not full.
- dout  out  DOUT_W  gearboxed word, bit 0 transmitted first.
- underflow  out  1  pulse: idle block inserted this cycle.

Behaviour:
- Reset values: dout=0, underflow=0, din_ready=1 after reset release, FIFO empty, bit count cnt=0, scrambler state 58'h3FF_FFFF_FFFF_FFFF.
- Input handshake:
  - Push when din_valid & din_ready.
  - din_ready = !full, registered-free (combinational from the FIFO count).
  - A push to a full FIFO cannot occur.
  - Push and pop in the same cycle are both honoured.
  - There is no empty-FIFO bypass: data pushed while empty is usable from the next cycle.
- Gearbox:
  - Bit buffer width 66+DOUT_W; counter cnt, width clog2(66+DOUT_W+1).
  - Each cycle with xcvr_tx_ready=1:
    - If cnt < DOUT_W: load one scrambled block at bit position cnt, then emit the low DOUT_W bits; cnt <= cnt+66-DOUT_W.
    - Else: emit only; cnt <= cnt-DOUT_W.
    - Buffer shifts right by DOUT_W after each emit.
- Block source on load:
  - FIFO non-empty: pop the FIFO head.
  - FIFO empty: use IDLE_BLOCK and pulse underflow for that cycle.
- Scrambler:
  - Self-synchronous, G(x)=1+x^39+x^58, applied to the 64 payload bits LSB first.
  - Sync header is never scrambled.
  - State advances only on a load.
  - SCRAM_BYPASS=1: payload passes through and state is frozen.
- Latency: dout registered; the first bit of a popped block appears on dout the cycle after its load.
- xcvr_tx_ready=0 (synchronous effect):
  - cnt <= 0, buffer cleared, dout <= 0, no pops.
  - Scrambler state retained.
  - FIFO keeps accepting until full.
  - On re-assert, the first block loads on the first cycle.
- Reset mid-operation: all state returns to reset values immediately; FIFO contents are discarded.
- Steady state DOUT_W=40: exactly 20 loads per 33 cycles.

Optional Feature:
- Macro SONIC_TX_GEARBOX_STATS_EN adds outputs stat_blocks[31:0] and stat_idles[31:0].
  - stat_blocks counts FIFO pops; stat_idles counts idle insertions.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
  - A new input, stat_clr, clears both synchronously; a clear takes priority over a same-cycle increment.
- Without the macro: no counters and no extra ports.

Decomposition:
- Package sonic_pcs_pkg holds:
  - SYNC_DATA=2'b10 and SYNC_CTRL=2'b01 (bit0 sent first).
  - BT_IDLE=8'h1E.
  - IDLE_BLOCK = {56'h0, BT_IDLE, SYNC_CTRL}.
  - SCRAM_SEED and the typedef block66_t.
- One sub-module: sonic_sync_fifo (parametrised width/depth, show-ahead, full/empty/count).
- Scrambler and gearbox stay inline.

Test Plan:
- Reset then xcvr_tx_ready=1, DOUT_W=40, FIFO kept non-empty -> cnt sequence 0,26,52,12,38,64,24..., 20 pops in 33 cycles, underflow never pulses.
- SCRAM_BYPASS=1, push 66'h2_0123_4567_89AB_CDEF (header 2'b11 suppressed; use header 2'b10) -> concatenated dout bits LSB first reproduce din exactly, header bits first.
- Empty FIFO after reset, SCRAM_BYPASS=1 -> first 66 emitted bits equal IDLE_BLOCK; underflow=1 on cycle 1 and on every load cycle.
- Push 9 blocks with xcvr_tx_ready=0, FIFO_DEPTH=8 -> din_ready falls after 8 pushes, the 9th is held; on ready-high, blocks emerge in order with no idle between.
- Scrambler reference model, 1000 random blocks, DOUT_W in {32,40,64} -> dout stream matches the model bit-exact; descrambled payload equals input.
- Deassert xcvr_tx_ready mid-block, then reassert -> dout=0 while low, cnt restarts at 0, no block lost from the FIFO; async reset mid-stream -> dout=0 in the same cycle and din_ready=1.
